// File: rtl/seg_display_pkg.sv
// Shared types and segment constants for the serial 7-segment display driver.
package seg_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2,
        LATCH   = 2'd3
    } state_t;

    // Segment bytes are {dp,g,f,e,d,c,b,a}, active-high; dp is never lit.
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_R     = 8'h50;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_display_driver_bin2bcd.sv
// Iterative double-dabble: one shift per cycle after start, DATA_WIDTH steps.
// The final step is presented combinationally on bcd while done is high, so
// the caller can use the result in the same cycle done is asserted.
module bin2bcd_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int BCD_DIGITS = (DATA_WIDTH * 3) / 10 + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   bin,
    output logic                    done,
    output logic [BCD_DIGITS*4-1:0] bcd
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0]   bin_q;
    logic [BCD_DIGITS*4-1:0] bcd_q;
    logic [BCD_DIGITS*4-1:0] adj;
    logic [BCD_DIGITS*4-1:0] step;
    logic [CW-1:0]           cnt_q;
    logic                    busy_q;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        step = {adj[BCD_DIGITS*4-2:0], bin_q[DATA_WIDTH-1]};
    end

    assign done = busy_q && (cnt_q == CW'(DATA_WIDTH - 1));
    assign bcd  = step;

    // Load on start, then advance one step per cycle until the last step is shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            bin_q  <= bin_q << 1;
            bcd_q  <= step;
            cnt_q  <= cnt_q + CW'(1);
            if (done) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_display_driver.sv
// Renders a signed magnitude (hex or decimal) as NUM_DIGITS segment bytes and
// streams them into a serial-in shift-register chain, then pulses the latch.
// Handshake: a request is taken on a cycle where i_valid && o_ready; o_ready is
// high only in IDLE, and inputs are not looked at in any other state.
// NUM_DIGITS must be at least 3 so the "Err" pattern fits.
module seg_display_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_is_neg,
    input  logic                  i_error,
    input  logic                  i_mode_dec,
    input  logic                  i_blank_lz,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_sr_data,
    output logic                  o_sr_clk,
    output logic                  o_sr_latch,
    output logic                  o_sr_oe_n
);
    import seg_display_pkg::*;

    localparam int BCD_DIGITS = (DATA_WIDTH * 3) / 10 + 1;
    localparam int HEX_DIGITS = (DATA_WIDTH + 3) / 4;
    localparam int SRC_DIGITS = (HEX_DIGITS > BCD_DIGITS) ? HEX_DIGITS : BCD_DIGITS;
    localparam int MAG_DIGITS = (SRC_DIGITS > NUM_DIGITS) ? SRC_DIGITS : NUM_DIGITS;
    localparam int MAG_W      = 4 * MAG_DIGITS;
    localparam int N_BITS     = 8 * NUM_DIGITS;
    localparam int BIT_CW     = $clog2(N_BITS);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    neg_q, err_q, dec_q, blank_q;
    logic                    handshake, conv_done, last_bit, bcd_done;
    logic [BCD_DIGITS*4-1:0] bcd;
    logic [MAG_W-1:0]        mag;
    logic [N_BITS-1:0]       frame, sr_q;
    logic                    phase_q;
    logic [BIT_CW-1:0]       bit_cnt_q;
    logic                    neg_eff, show_err;
    int                      sig;

    assign o_ready   = (state_q == IDLE);
    assign handshake = o_ready && i_valid;
    assign conv_done = (state_q == CONVERT) && (!dec_q || bcd_done);
    assign last_bit  = phase_q && (bit_cnt_q == BIT_CW'(N_BITS - 1));

    bin2bcd_seq #(
        .DATA_WIDTH(DATA_WIDTH),
        .BCD_DIGITS(BCD_DIGITS)
    ) u_bin2bcd (
        .clk  (clk),
        .rst_n(rst_n),
        .start(handshake),
        .bin  (i_data),
        .done (bcd_done),
        .bcd  (bcd)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: hex converts in one cycle, decimal waits for the converter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid)   state_d = CONVERT;
            CONVERT: if (conv_done) state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = LATCH;
            LATCH:                  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Capture the request on the handshake cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            dec_q   <= 1'b0;
            blank_q <= 1'b0;
        end else if (handshake) begin
            data_q  <= i_data;
            neg_q   <= i_data_is_neg;
            err_q   <= i_error;
            dec_q   <= i_mode_dec;
            blank_q <= i_blank_lz;
        end
    end

    // Digit build: choose magnitude digits, find the top nonzero digit, place sign/Err.
    always_comb begin
        mag = dec_q ? MAG_W'(bcd) : MAG_W'(data_q);
        sig = 0;
        for (int i = 0; i < MAG_DIGITS; i++) begin
            if (mag[4*i +: 4] != 4'd0) sig = i;
        end
        neg_eff  = neg_q && (data_q != '0);
        show_err = err_q || ((sig + int'(neg_eff)) >= NUM_DIGITS);
        frame    = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (show_err) begin
                frame[8*d +: 8] = (d == 2) ? SEG_E : ((d < 2) ? SEG_R : SEG_BLANK);
            end else if (blank_q) begin
                if (d <= sig)                      frame[8*d +: 8] = hex_to_seg(mag[4*d +: 4]);
                else if (neg_eff && d == sig + 1)  frame[8*d +: 8] = SEG_MINUS;
                else                               frame[8*d +: 8] = SEG_BLANK;
            end else if (neg_eff && d == NUM_DIGITS - 1) begin
                frame[8*d +: 8] = SEG_MINUS;
            end else begin
                frame[8*d +: 8] = hex_to_seg(mag[4*d +: 4]);
            end
        end
    end

    // Serial output: two cycles per bit (data then rising shift clock), then latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            phase_q    <= 1'b0;
            o_sr_data  <= 1'b0;
            o_sr_clk   <= 1'b0;
            o_sr_latch <= 1'b0;
            o_sr_oe_n  <= 1'b1;
        end else begin
            o_sr_latch <= 1'b0;
            case (state_q)
                CONVERT: begin
                    if (conv_done) begin
                        sr_q      <= frame;
                        o_sr_data <= frame[N_BITS-1];
                        o_sr_clk  <= 1'b0;
                        phase_q   <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (!phase_q) begin
                        phase_q  <= 1'b1;
                        o_sr_clk <= 1'b1;
                    end else begin
                        phase_q  <= 1'b0;
                        o_sr_clk <= 1'b0;
                        if (last_bit) begin
                            o_sr_latch <= 1'b1;
                            o_sr_oe_n  <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CW'(1);
                            sr_q      <= sr_q << 1;
                            o_sr_data <= sr_q[N_BITS-2];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed and randomized bench for seg_display_driver with a digit-level
// reference model and an expected-byte queue.
module tb_seg_display_driver;
    localparam int DW = 16;
    localparam int ND = 5;
    localparam int NB = 8 * ND;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] i_data = '0;
    logic          i_data_is_neg = 1'b0;
    logic          i_error = 1'b0;
    logic          i_mode_dec = 1'b0;
    logic          i_blank_lz = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready, o_sr_data, o_sr_clk, o_sr_latch, o_sr_oe_n;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   exp_lat = 0;
    logic [7:0] exp_q[$];
    logic       bits_q[$];
    logic [7:0] seg_tab[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    seg_display_driver #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_data       (i_data),
        .i_data_is_neg(i_data_is_neg),
        .i_error      (i_error),
        .i_mode_dec   (i_mode_dec),
        .i_blank_lz   (i_blank_lz),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_sr_data    (o_sr_data),
        .o_sr_clk     (o_sr_clk),
        .o_sr_latch   (o_sr_latch),
        .o_sr_oe_n    (o_sr_oe_n)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The chain samples data on each rising shift clock.
    always @(posedge o_sr_clk) bits_q.push_back(o_sr_data);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: render the number as text digits by repeated division, then place
    // sign, padding or the Err pattern into ND display positions (leftmost first).
    function automatic void model(input logic [DW-1:0] d, input bit neg, input bit err,
                                  input bit dec, input bit blank);
        int base, v, nd;
        int dig[8];
        bit neg_eff, ovf;
        logic [7:0] c;
        base = dec ? 10 : 16;
        v = int'(d);
        nd = 0;
        for (int i = 0; i < 8; i++) dig[i] = 0;
        neg_eff = neg && (d != 0);
        do begin
            dig[nd] = v % base;
            v = v / base;
            nd++;
        end while (v != 0);
        ovf = err || ((nd + int'(neg_eff)) > ND);
        for (int p = ND - 1; p >= 0; p--) begin
            if (ovf)        c = (p == 2) ? 8'h79 : ((p < 2) ? 8'h50 : 8'h00);
            else if (blank) c = (p < nd) ? seg_tab[dig[p]] : ((neg_eff && p == nd) ? 8'h40 : 8'h00);
            else            c = (neg_eff && p == ND - 1) ? 8'h40 : seg_tab[dig[p]];
            exp_q.push_back(c);
        end
        exp_lat = 1 + (dec ? DW : 1) + 2 * NB;
    endfunction

    // Driver: wait for ready, present one request, release i_valid unless held.
    task automatic send(input logic [DW-1:0] d, input bit neg, input bit err,
                        input bit dec, input bit blank, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", o_ready, 1'b1);
        i_data = d; i_data_is_neg = neg; i_error = err; i_mode_dec = dec; i_blank_lz = blank;
        i_valid = 1'b1;
        t0 = cyc;
        model(d, neg, err, dec, blank);
        bits_q.delete();
        @(negedge clk);
        if (!hold) i_valid = 1'b0;
    endtask

    // Wait for the latch, then score timing, clock count, enable and every byte.
    task automatic collect(input bit first_frame);
        int n;
        logic oe_prev;
        logic [7:0] b;
        n = 0;
        oe_prev = o_sr_oe_n;
        while (!o_sr_latch && n < 400) begin
            oe_prev = o_sr_oe_n;
            @(negedge clk);
            n++;
        end
        check("latch_seen", o_sr_latch, 1'b1);
        if (!o_sr_latch) begin
            exp_q.delete();
            return;
        end
        check("latch_cycle", cyc - t0, exp_lat);
        check("sr_clk_low_at_latch", o_sr_clk, 1'b0);
        check("oe_on_at_latch", o_sr_oe_n, 1'b0);
        if (first_frame) check("oe_off_before_latch", oe_prev, 1'b1);
        check("sr_clk_rises", bits_q.size(), NB);
        for (int k = 0; k < ND; k++) begin
            b = '0;
            for (int j = 0; j < 8; j++)
                b = {b[6:0], (bits_q.size() > k * 8 + j) ? bits_q[k * 8 + j] : 1'b0};
            check($sformatf("byte%0d", k), b, exp_q.pop_front());
        end
        @(negedge clk);
        check("latch_one_cycle", o_sr_latch, 1'b0);
        check("ready_after_latch", o_ready, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] d;
        // Reset block.
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", o_ready, 1'b1);
        check("rst_oe_n", o_sr_oe_n, 1'b1);
        check("rst_sr_clk", o_sr_clk, 1'b0);
        check("rst_sr_data", o_sr_data, 1'b0);
        check("rst_latch", o_sr_latch, 1'b0);
        rst_n = 1'b1;

        // Directed frames.
        send(16'h00AB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); collect(1'b1);
        send(16'd1234, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); collect(1'b0);
        send(16'd65535, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); collect(1'b0);
        send(16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); collect(1'b0);
        send(16'd12345, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); collect(1'b0);
        send(16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); collect(1'b0);
        send(16'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); collect(1'b0);

        // i_valid held through a frame while the inputs change underneath it.
        send(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        i_data = 16'd3054; i_data_is_neg = 1'b1; i_mode_dec = 1'b1; i_blank_lz = 1'b1;
        repeat (20) @(negedge clk);
        check("ready_low_while_busy", o_ready, 1'b0);
        collect(1'b0);
        t0 = cyc;
        model(16'd3054, 1'b1, 1'b0, 1'b1, 1'b1);
        bits_q.delete();
        @(negedge clk);
        i_valid = 1'b0;
        check("b2b_accepted", o_ready, 1'b0);
        collect(1'b0);

        // Reset in the middle of a shift.
        send(16'd4321, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_oe_n", o_sr_oe_n, 1'b1);
        check("midrst_sr_clk", o_sr_clk, 1'b0);
        check("midrst_sr_data", o_sr_data, 1'b0);
        check("midrst_latch", o_sr_latch, 1'b0);
        check("midrst_ready", o_ready, 1'b1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(16'hF00D, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); collect(1'b1);

        // Randomized requests, biased toward short values so blanking matters.
        for (int r = 0; r < 16; r++) begin
            d = DW'($urandom) >> $urandom_range(0, 15);
            send(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            collect(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
